// File: rtl/add_round_key_stream.sv
// add_round_key_stream: lane-serial AES AddRoundKey over a streaming block.
// A block and a snapshot of its round key are captured on accept, XORed one
// LANE_W-bit lane per cycle (MSB lane first), then held until downstream takes it.
// Optional feature macro: ARK_RANGE_CHECK_EN (out-of-range round index passes the
// block through unmodified and flags out_err; otherwise key[0] is used).
module add_round_key_stream #(
  parameter int DATA_W   = 128,
  parameter int LANE_W   = 32,
  parameter int NUM_KEYS = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_we,
  input  logic [$clog2(NUM_KEYS)-1:0] key_waddr,
  input  logic [DATA_W-1:0]           key_wdata,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(NUM_KEYS)-1:0] in_round,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_err
);

  localparam int AW    = $clog2(NUM_KEYS);
  localparam int BEATS = DATA_W / LANE_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]     LAST_BEAT = CW'(BEATS - 1);
  localparam logic [DATA_W-1:0] LANE_ONES = {DATA_W{1'b1}} >> (DATA_W - LANE_W);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0] key_q [NUM_KEYS];
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] key_sel;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] out_data_q;
  logic              accept;
  logic              last_beat;

  // True when an index addresses a real entry of the key store.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return 32'(idx) < NUM_KEYS;
  endfunction

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_beat = (state_q == PROC) && (beat_q == LAST_BEAT);
  assign out_data  = out_data_q;

`ifdef ARK_RANGE_CHECK_EN
  logic err_sel;
  logic err_snap_q;
  logic out_err_q;

  // Select the round key for the incoming block; out-of-range keys read as zero.
  always_comb begin
    key_sel = '0;
    err_sel = 1'b1;
    if (idx_ok(in_round)) begin
      key_sel = key_q[in_round];
      err_sel = 1'b0;
    end
  end

  // Error flag is snapshotted at accept and published together with the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_snap_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      if (accept)    err_snap_q <= err_sel;
      if (last_beat) out_err_q  <= err_snap_q;
    end
  end

  assign out_err = out_err_q;
`else
  // Select the round key for the incoming block; out-of-range indices fall back to key[0].
  always_comb begin
    key_sel = key_q[0];
    if (idx_ok(in_round)) key_sel = key_q[in_round];
  end

  assign out_err = 1'b0;
`endif

  // Lane currently being processed: beat 0 is the most significant lane.
  always_comb begin
    lane_mask = LANE_ONES << (LANE_W * (BEATS - 1 - int'(beat_q)));
    acc_d     = acc_q ^ (snap_q & lane_mask);
  end

  // Next-state and handshake decode for the IDLE -> PROC -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = PROC;
          beat_d  = '0;
        end
      end
      PROC: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
          beat_d  = '0;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Round-key store; writes to indices beyond the store are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
    end else if (key_we && idx_ok(key_waddr)) begin
      key_q[key_waddr] <= key_wdata;
    end
  end

  // Working registers: block and key snapshot captured on accept, then lane-wise XOR.
  // The snapshot decouples the in-flight block from later key-store writes.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q  <= in_data;
      snap_q <= key_sel;
    end else if (state_q == PROC) begin
      acc_q <= acc_d;
    end
  end

  // Published result only changes when a block completes, so it holds through IDLE/PROC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_data_q <= '0;
    else if (last_beat) out_data_q <= acc_d;
  end

endmodule

// File: tb/tb_add_round_key_stream.sv
// Testbench for add_round_key_stream: directed table, multi-cycle corner cases,
// and randomized blocks/key writes checked against a key-store reference model.
module tb_add_round_key_stream;

  localparam int NUM_KEYS = 15;
`ifdef ARK_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VD  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VE  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] KA  = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] KB  = 128'hdeadbeef_cafef00d_0badc0de_13572468;
  localparam logic [127:0] KC  = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  localparam logic [127:0] KD  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] K3  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] K5  = 128'h89abcdef_01234567_89abcdef_01234567;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;
  logic         in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_round;
  logic         out_ready;
  logic         in_ready, out_valid, out_err;
  logic [127:0] out_data;
  logic         in_ready8, out_valid8, out_err8;
  logic [127:0] out_data8;
  logic         in_ready128, out_valid128, out_err128;
  logic [127:0] out_data128;

  int n_pass = 0;
  int n_total = 0;
  bit [127:0] mkey [NUM_KEYS];

  add_round_key_stream dut (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err));

  add_round_key_stream #(.LANE_W(8)) u8 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_err(out_err8));

  add_round_key_stream #(.LANE_W(128)) u128 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
    .in_valid(in_valid), .in_ready(in_ready128), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid128), .out_ready(out_ready), .out_data(out_data128), .out_err(out_err128));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result of a block given the key store contents at accept time.
  function automatic bit [128:0] model_result(input bit [127:0] d, input int r);
    if (r < NUM_KEYS) return {1'b0, d ^ mkey[r]};
    if (RC) return {1'b1, d};
    return {1'b0, d ^ mkey[0]};
  endfunction

  function automatic void model_write(input int a, input bit [127:0] v);
    if (a < NUM_KEYS) mkey[a] = v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_KEYS; i++) mkey[i] = '0;
  endfunction

  function automatic bit [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic write_key(input int a, input bit [127:0] v);
    key_we = 1'b1; key_waddr = 4'(a); key_wdata = v;
    tick();
    key_we = 1'b0;
    model_write(a, v);
  endtask

  // wr_when: 0 none, 1 key write on the accepting edge, 2 key write on the first PROC edge.
  task automatic run_block(input bit [127:0] d, input int r, input bit [127:0] exp_d,
                           input bit exp_e, input string nm, input int wr_when,
                           input int wr_a, input bit [127:0] wr_v);
    int lat;
    chk({nm, " in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_data = d; in_round = 4'(r);
    if (wr_when == 1) begin key_we = 1'b1; key_waddr = 4'(wr_a); key_wdata = wr_v; end
    tick();
    in_valid = 1'b0; key_we = 1'b0;
    if (wr_when == 1) model_write(wr_a, wr_v);
    lat = 0;
    if (wr_when == 2) begin
      key_we = 1'b1; key_waddr = 4'(wr_a); key_wdata = wr_v;
      tick(); lat++;
      key_we = 1'b0;
      model_write(wr_a, wr_v);
    end
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk({nm, " latency"}, 128'(lat), 128'(4));
    chk({nm, " out_data"}, out_data, exp_d);
    chk({nm, " out_err"}, 128'(out_err), 128'(exp_e));
    tick();
  endtask

  typedef struct {
    int           round;
    logic [127:0] data;
    logic [127:0] exp_d;
    logic         exp_e;
  } vec_t;

  initial begin : main
    vec_t tv [6];
    int lat, l32, l8, l128;
    logic [127:0] d32, d8, d128, dd;
    bit [128:0] e;
    bit spurious;

    rst = 1'b1; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    in_valid = 1'b0; in_data = '0; in_round = '0; out_ready = 1'b1;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_data", out_data, '0);
    chk("reset out_err", 128'(out_err), 128'(0));
    chk("reset in_ready lane8", 128'(in_ready8), 128'(1));
    chk("reset in_ready lane128", 128'(in_ready128), 128'(1));

    // Reference vector across three lane widths
    write_key(0, K0);
    in_valid = 1'b1; in_data = VD; in_round = 4'd0;
    tick();
    in_valid = 1'b0;
    l32 = -1; l8 = -1; l128 = -1; lat = 0;
    d32 = '0; d8 = '0; d128 = '0;
    while ((l32 < 0 || l8 < 0 || l128 < 0) && lat < 40) begin
      tick(); lat++;
      if (out_valid && l32 < 0)     begin l32 = lat;  d32 = out_data;     end
      if (out_valid8 && l8 < 0)     begin l8 = lat;   d8 = out_data8;     end
      if (out_valid128 && l128 < 0) begin l128 = lat; d128 = out_data128; end
    end
    chk("vec lane32 latency", 128'(l32), 128'(4));
    chk("vec lane32 data", d32, VE);
    chk("vec lane8 latency", 128'(l8), 128'(16));
    chk("vec lane8 data", d8, VE);
    chk("vec lane128 latency", 128'(l128), 128'(1));
    chk("vec lane128 data", d128, VE);
    chk("vec lane8 out_err", 128'(out_err8), 128'(0));
    chk("vec lane128 out_err", 128'(out_err128), 128'(0));
    tick();

    // Directed table
    write_key(1, KA);
    write_key(14, KB);
    write_key(7, KC);
    write_key(15, KD);
    tv[0] = '{1,  128'hffeeddccbbaa99887766554433221100, 128'hffeeddccbbaa99887766554433221100 ^ KA, 1'b0};
    tv[1] = '{14, 128'h0000000000000000ffffffffffffffff, 128'h0000000000000000ffffffffffffffff ^ KB, 1'b0};
    tv[2] = '{7,  128'h13579bdf2468ace0fdb97531eca86420, 128'h13579bdf2468ace0fdb97531eca86420 ^ KC, 1'b0};
    tv[3] = '{2,  128'hcafebabe_00000000_12345678_9abcdef0, 128'hcafebabe_00000000_12345678_9abcdef0, 1'b0};
    tv[4] = '{0,  VD, VE, 1'b0};
    tv[5] = '{15, 128'h8899aabbccddeeff0011223344556677,
              RC ? 128'h8899aabbccddeeff0011223344556677
                 : (128'h8899aabbccddeeff0011223344556677 ^ K0), RC};
    for (int i = 0; i < 6; i++)
      run_block(tv[i].data, tv[i].round, tv[i].exp_d, tv[i].exp_e,
                $sformatf("table[%0d]", i), 0, 0, '0);

    // Key write to in-flight index during PROC uses the snapshot
    write_key(3, K3);
    run_block(VD, 3, VD ^ K3, 1'b0, "inflight write", 2, 3, ONES);
    run_block(VD, 3, ~VD, 1'b0, "after inflight write", 0, 0, '0);

    // Simultaneous write and accept on the same index uses the old key
    write_key(5, K5);
    run_block(VD, 5, VD ^ K5, 1'b0, "same-edge write", 1, 5, ~K5);
    run_block(VD, 5, ~(VD ^ K5), 1'b0, "after same-edge write", 0, 0, '0);

    // Backpressure: DONE held, then no accept on the releasing edge
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = VE; in_round = 4'd1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("bp latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp hold out_valid %0d", i), 128'(out_valid), 128'(1));
      chk($sformatf("bp hold out_data %0d", i), out_data, VE ^ KA);
      chk($sformatf("bp hold in_ready %0d", i), 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = VD; in_round = 4'd0;
    tick();
    chk("bp release out_valid", 128'(out_valid), 128'(0));
    chk("bp release no accept", 128'(in_ready), 128'(1));
    chk("bp release data held", out_data, VE ^ KA);
    tick();
    in_valid = 1'b0;
    chk("bp next in_ready", 128'(in_ready), 128'(0));
    chk("bp next data held", out_data, VE ^ KA);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("bp next latency", 128'(lat), 128'(4));
    chk("bp next out_data", out_data, VE);
    tick();

    // Reset asserted during beat 2
    in_valid = 1'b1; in_data = VD; in_round = 4'd1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst in_ready", 128'(in_ready), 128'(1));
    chk("midrst out_valid", 128'(out_valid), 128'(0));
    chk("midrst out_data", out_data, '0);
    chk("midrst out_err", 128'(out_err), 128'(0));
    model_clear();
    tick();
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) spurious = 1'b1;
    end
    chk("midrst no spurious out_valid", 128'(spurious), 128'(0));
    run_block(VD, 1, VD, 1'b0, "midrst key1 cleared", 0, 0, '0);
    run_block(VD, 0, VD, 1'b0, "midrst key0 cleared", 0, 0, '0);

    // Randomized blocks and key writes against the reference model
    for (int i = 0; i < 40; i++) begin
      int r, wa, ww;
      bit [127:0] d, wv;
      wa = $urandom_range(0, 15);
      wv = rnd128();
      write_key(wa, wv);
      d  = rnd128();
      r  = $urandom_range(0, 15);
      ww = $urandom_range(0, 2);
      wa = $urandom_range(0, 15);
      wv = rnd128();
      e  = model_result(d, r);
      dd = e[127:0];
      run_block(d, r, dd, e[128], $sformatf("rand[%0d]", i), ww, wa, wv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/add_round_key_stream.md
ADD_ROUND_KEY_STREAM -- requirements
Module: add_round_key_stream

Interface
REQ-001 Parameter DATA_W, 128, state/key block width in bits.
REQ-002 Parameter LANE_W, 32, bits XORed per cycle; DATA_W SHALL be an integer multiple of LANE_W; BEATS = DATA_W/LANE_W.
REQ-003 Parameter NUM_KEYS, 15, round-key store depth (AES-256 worst case).
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port key_we  input  1  round-key store write enable.
REQ-007 Port key_waddr  input  $clog2(NUM_KEYS)  round-key write index.
REQ-008 Port key_wdata  input  DATA_W  round-key write data.
REQ-009 Port in_valid  input  1  input block valid.
REQ-010 Port in_ready  output  1  block can be accepted.
REQ-011 Port in_data  input  DATA_W  state block.
REQ-012 Port in_round  input  $clog2(NUM_KEYS)  round-key index for this block.
REQ-013 Port out_valid  output  1  result valid.
REQ-014 Port out_ready  input  1  downstream accepts result.
REQ-015 Port out_data  output  DATA_W  state XOR selected round key.
REQ-016 Port out_err  output  1  result used an out-of-range index (see Configuration).

Function
REQ-017 The block SHALL implement FSM states IDLE, PROC, DONE.
REQ-018 IDLE: in_ready=1; in_valid=1 at an edge SHALL capture in_data and a snapshot of key[in_round], clear beat counter, go to PROC.
REQ-019 PROC: each edge SHALL XOR beat k's lane, bits [DATA_W-1-k*LANE_W -: LANE_W] (MSB lane first), into the result register and increment k; at k==BEATS-1 go to DONE.
REQ-020 DONE: out_valid=1, out_data/out_err stable; out_ready=1 at an edge SHALL return to IDLE.
REQ-021 out_valid SHALL rise exactly BEATS edges after the accepting edge (4 for defaults).
REQ-022 in_ready SHALL be 0 in PROC and DONE; no new block is accepted in the edge that releases DONE (max throughput one block per BEATS+2 cycles).
REQ-023 out_valid SHALL be 0 in IDLE and PROC; out_data SHALL hold its last value until the next DONE.
REQ-024 key_we with key_waddr<NUM_KEYS SHALL write the store at the edge; key_waddr>=NUM_KEYS SHALL be ignored.
REQ-025 A key write to the index of an in-flight block SHALL NOT alter that block's result (snapshot at accept).
REQ-026 Simultaneous key write and block accept on the same index SHALL use the old key value.
REQ-027 Backpressure (out_ready=0) SHALL hold DONE indefinitely with no data change.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, beat counter 0, in_ready=1, out_valid=0, out_data=0, out_err=0, all key store entries 0.
REQ-029 Reset mid-PROC or mid-DONE SHALL discard the block; no out_valid after reset release until a new accept.

Configuration
REQ-030 Macro ARK_RANGE_CHECK_EN defined: in_round>=NUM_KEYS at accept SHALL pass in_data unmodified (key treated as 0) and assert out_err=1 in DONE.
REQ-031 Macro ARK_RANGE_CHECK_EN undefined: in_round>=NUM_KEYS SHALL use key[0]; out_err SHALL be constant 0.

Verification
REQ-032 Defaults; key[0]=000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff round 0 -> out_data=00102030405060708090a0b0c0d0e0f0, out_valid 4 edges after accept.
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout; release -> IDLE next edge.
REQ-034 Accept block round 3, write key[3]=FF..FF during PROC -> result uses pre-write key[3]; next block round 3 uses FF..FF.
REQ-035 in_round=15, NUM_KEYS=15 -> with ARK_RANGE_CHECK_EN out_data=in_data, out_err=1; without, out_data=in_data^key[0], out_err=0.
REQ-036 Assert rst during beat 2 -> immediate IDLE, out_valid=0, out_data=0, keys 0; no spurious output after release.
REQ-037 LANE_W=8 and LANE_W=128 builds with vector of REQ-032 -> same out_data, latency 16 and 1 edges respectively.
